// File: rtl/dma_lite_pkg.sv
// Shared AXI-Lite register map, DMASR bit layout, response codes and FSM
// encoding for the DMA lite register slave and its companion read master.
package dma_lite_pkg;

    localparam logic [9:0] MM2S_DMASR_OFFSET = 10'h004;
    localparam logic [9:0] S2MM_DMASR_OFFSET = 10'h034;

    localparam int unsigned DMASR_HALTED_BIT = 0;
    localparam int unsigned DMASR_IDLE_BIT   = 1;
    localparam int unsigned DMASR_ERR_BIT    = 4;
    localparam int unsigned DMASR_IOC_BIT    = 12;

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;

    typedef enum logic [1:0] {
        LITE_INIT = 2'd0,
        LITE_IDLE = 2'd1,
        LITE_RESP = 2'd2
    } lite_state_e;

    // Assemble a DMASR word; bits not named here always read as zero.
    function automatic logic [31:0] dmasr_word(
        input logic halted,
        input logic idle,
        input logic err,
        input logic ioc
    );
        logic [31:0] w;
        w                   = '0;
        w[DMASR_HALTED_BIT] = halted;
        w[DMASR_IDLE_BIT]   = idle;
        w[DMASR_ERR_BIT]    = err;
        w[DMASR_IOC_BIT]    = ioc;
        return w;
    endfunction

endpackage

// File: rtl/lite_sticky_bit.sv
// Single sticky status flag: set by an event pulse, cleared by a read,
// with set winning when both happen on the same edge.
module lite_sticky_bit (
    input  logic clk,
    input  logic rst_n,
    input  logic set,
    input  logic clr,
    output logic q
);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            q <= 1'b0;
        end else if (set) begin
            q <= 1'b1;
        end else if (clr) begin
            q <= 1'b0;
        end
    end

endmodule

// File: rtl/lite_read_slave.sv
// AXI-Lite read-only slave exposing the MM2S and S2MM DMA status registers,
// one read outstanding, registered AR/R channel outputs.
module lite_read_slave
    import dma_lite_pkg::*;
#(
    parameter int unsigned            ADDR_WIDTH   = 10,
    parameter int unsigned            DATA_WIDTH   = 32,
    parameter logic [ADDR_WIDTH-1:0]  MM2S_SR_ADDR = ADDR_WIDTH'(MM2S_DMASR_OFFSET),
    parameter logic [ADDR_WIDTH-1:0]  S2MM_SR_ADDR = ADDR_WIDTH'(S2MM_DMASR_OFFSET)
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [ADDR_WIDTH-1:0] s_axi_lite_araddr,
    input  logic                  s_axi_lite_arvalid,
    output logic                  s_axi_lite_arready,
    output logic [DATA_WIDTH-1:0] s_axi_lite_rdata,
    output logic [1:0]            s_axi_lite_rresp,
    output logic                  s_axi_lite_rvalid,
    input  logic                  s_axi_lite_rready,
    input  logic                  mm2s_halted,
    input  logic                  mm2s_idle,
    input  logic                  s2mm_halted,
    input  logic                  s2mm_idle,
    input  logic                  mm2s_ioc,
    input  logic                  s2mm_ioc,
    input  logic                  s2mm_err
);

    lite_state_e           state;
    lite_state_e           next_state;
    logic                  arready_q;
    logic                  arready_d;
    logic                  rvalid_q;
    logic                  rvalid_d;
    logic [DATA_WIDTH-1:0] rdata_q;
    logic [1:0]            rresp_q;

    logic                  ar_hs;
    logic                  r_hs;
    logic                  addr_aligned;
    logic                  hit_mm2s;
    logic                  hit_s2mm;
    logic [31:0]           rd_word;
    logic [1:0]            rd_resp;

    logic                  mm2s_ioc_q;
    logic                  s2mm_ioc_q;
    logic                  s2mm_err_q;

    assign ar_hs = s_axi_lite_arvalid & arready_q;
    assign r_hs  = rvalid_q & s_axi_lite_rready;

    // ---------------------------------------------------------------- FSM
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= LITE_INIT;
            arready_q <= 1'b0;
            rvalid_q  <= 1'b0;
        end else begin
            state     <= next_state;
            arready_q <= arready_d;
            rvalid_q  <= rvalid_d;
        end
    end

    always_comb begin
        next_state = state;
        case (state)
            LITE_INIT: next_state = LITE_IDLE;
            LITE_IDLE: if (ar_hs) next_state = LITE_RESP;
            LITE_RESP: if (r_hs)  next_state = LITE_IDLE;
            default:   next_state = LITE_INIT;
        endcase
    end

    // Outputs are registered from next_state so they line up with the state
    // they belong to; leaving INIT holds arready low one extra cycle.
    always_comb begin
        arready_d = 1'b0;
        rvalid_d  = 1'b0;
        if (next_state == LITE_IDLE && state != LITE_INIT) begin
            arready_d = 1'b1;
        end
        if (next_state == LITE_RESP) begin
            rvalid_d = 1'b1;
        end
    end

    // ------------------------------------------------------- address decode
    assign addr_aligned = (s_axi_lite_araddr[1:0] == 2'b00);
    assign hit_mm2s     = (s_axi_lite_araddr == MM2S_SR_ADDR);
    assign hit_s2mm     = (s_axi_lite_araddr == S2MM_SR_ADDR);

    always_comb begin
        rd_word = '0;
        rd_resp = RESP_OKAY;
        if (!addr_aligned) begin
            rd_resp = RESP_SLVERR;
        end else if (hit_mm2s) begin
            rd_word = dmasr_word(mm2s_halted, mm2s_idle, 1'b0, mm2s_ioc_q);
        end else if (hit_s2mm) begin
            rd_word = dmasr_word(s2mm_halted, s2mm_idle, s2mm_err_q, s2mm_ioc_q);
        end
    end

    // ------------------------------------------------------- sticky flags
    lite_sticky_bit u_mm2s_ioc (
        .clk   (clk),
        .rst_n (rst_n),
        .set   (mm2s_ioc),
        .clr   (ar_hs & addr_aligned & hit_mm2s),
        .q     (mm2s_ioc_q)
    );

    lite_sticky_bit u_s2mm_ioc (
        .clk   (clk),
        .rst_n (rst_n),
        .set   (s2mm_ioc),
        .clr   (ar_hs & addr_aligned & hit_s2mm),
        .q     (s2mm_ioc_q)
    );

    lite_sticky_bit u_s2mm_err (
        .clk   (clk),
        .rst_n (rst_n),
        .set   (s2mm_err),
        .clr   (ar_hs & addr_aligned & hit_s2mm),
        .q     (s2mm_err_q)
    );

    // ---------------------------------------------------------- read data
    // Captured only on the AR handshake, so level changes and new sticky
    // events during RESP never disturb the word being returned.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rdata_q <= '0;
            rresp_q <= RESP_OKAY;
        end else if (ar_hs) begin
            rdata_q <= DATA_WIDTH'(rd_word);
            rresp_q <= rd_resp;
        end
    end

    assign s_axi_lite_arready = arready_q;
    assign s_axi_lite_rvalid  = rvalid_q;
    assign s_axi_lite_rdata   = rdata_q;
    assign s_axi_lite_rresp   = rresp_q;

    // ---------------------------------------------------- protocol checks
    a_one_channel : assert property (@(posedge clk) disable iff (!rst_n)
        !(arready_q && rvalid_q));

    a_r_hold : assert property (@(posedge clk) disable iff (!rst_n)
        (rvalid_q && !s_axi_lite_rready) |=>
            (rvalid_q && $stable(rdata_q) && $stable(rresp_q)));

endmodule

// File: tb/tb_lite_read_slave.sv
// Scoreboard bench for lite_read_slave: a register-map model predicts each
// read at its address handshake, an independent monitor checks the R channel.
module tb_lite_read_slave;

    logic        clk;
    logic        rst_n;
    logic [9:0]  araddr;
    logic        arvalid;
    logic        arready;
    logic [31:0] rdata;
    logic [1:0]  rresp;
    logic        rvalid;
    logic        rready;
    logic        mm2s_halted, mm2s_idle, s2mm_halted, s2mm_idle;
    logic        mm2s_ioc, s2mm_ioc, s2mm_err;

    lite_read_slave #(
        .ADDR_WIDTH   (10),
        .DATA_WIDTH   (32),
        .MM2S_SR_ADDR (10'h004),
        .S2MM_SR_ADDR (10'h034)
    ) dut (
        .clk                (clk),
        .rst_n              (rst_n),
        .s_axi_lite_araddr  (araddr),
        .s_axi_lite_arvalid (arvalid),
        .s_axi_lite_arready (arready),
        .s_axi_lite_rdata   (rdata),
        .s_axi_lite_rresp   (rresp),
        .s_axi_lite_rvalid  (rvalid),
        .s_axi_lite_rready  (rready),
        .mm2s_halted        (mm2s_halted),
        .mm2s_idle          (mm2s_idle),
        .s2mm_halted        (s2mm_halted),
        .s2mm_idle          (s2mm_idle),
        .mm2s_ioc           (mm2s_ioc),
        .s2mm_ioc           (s2mm_ioc),
        .s2mm_err           (s2mm_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        logic [31:0] data;
        logic [1:0]  resp;
        int          hs;
    } exp_t;

    exp_t        sb[$];
    int          total = 0;
    int          bad = 0;
    int          r_done = 0;
    bit          front_seen = 0;
    bit          last_hs = 0;
    bit          rand_ev = 0;
    logic [31:0] last_rdata;
    logic [1:0]  last_rresp;

    // reference model: sticky flags as plain booleans
    bit m_mm2s_ioc = 0, m_s2mm_ioc = 0, m_s2mm_err = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s actual=%h required=%h (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic exp_t predict(input logic [9:0] a);
        exp_t e;
        e.data = 32'd0;
        e.resp = 2'b00;
        e.hs   = 0;
        if (a % 4 != 0) begin
            e.resp = 2'b10;
        end else if (a == 10'h004) begin
            e.data = (32'(m_mm2s_ioc) << 12) | (32'(mm2s_idle) << 1) | 32'(mm2s_halted);
        end else if (a == 10'h034) begin
            e.data = (32'(m_s2mm_ioc) << 12) | (32'(m_s2mm_err) << 4)
                   | (32'(s2mm_idle) << 1) | 32'(s2mm_halted);
        end
        return e;
    endfunction

    // One clock: inputs are already set for the coming rising edge.
    task automatic tick();
        exp_t e;
        if (rand_ev) begin
            mm2s_ioc |= ($urandom_range(0, 5) == 0);
            s2mm_ioc |= ($urandom_range(0, 5) == 0);
            s2mm_err |= ($urandom_range(0, 7) == 0);
            if ($urandom_range(0, 3) == 0) begin
                mm2s_halted = 1'($urandom); mm2s_idle = 1'($urandom);
                s2mm_halted = 1'($urandom); s2mm_idle = 1'($urandom);
            end
        end
        last_hs = rst_n && arvalid && arready;
        if (last_hs) begin
            e = predict(araddr);
            e.hs = cyc + 1;
            sb.push_back(e);
            if (araddr == 10'h004) m_mm2s_ioc = 0;
            if (araddr == 10'h034) begin m_s2mm_ioc = 0; m_s2mm_err = 0; end
        end
        if (rst_n) begin
            if (mm2s_ioc) m_mm2s_ioc = 1;
            if (s2mm_ioc) m_s2mm_ioc = 1;
            if (s2mm_err) m_s2mm_err = 1;
        end
        @(negedge clk);
        mm2s_ioc = 0; s2mm_ioc = 0; s2mm_err = 0;
    endtask

    task automatic do_read(input logic [9:0] a, input int hold, input bit ioc_on_hs);
        int start, n;
        bit got;
        araddr = a; arvalid = 1; rready = (hold == 0);
        start = r_done; n = 0; got = 0;
        while (!got && n < 20) begin
            if (ioc_on_hs && arready) s2mm_ioc = 1;
            tick();
            got = last_hs;
            n++;
        end
        chk("ar_handshake", 32'(got), 32'd1);
        arvalid = 0;
        araddr = 10'($urandom);
        for (int i = 0; i < hold; i++) begin
            mm2s_idle = ~mm2s_idle;
            tick();
        end
        rready = 1; n = 0;
        while (r_done == start && n < 20) begin tick(); n++; end
        chk("r_handshake", 32'(r_done != start), 32'd1);
        rready = 1'($urandom);
    endtask

    // monitor: compares whatever the R channel shows against the scoreboard
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            #2;
            if (rst_n) begin
                if (rvalid) begin
                    if (sb.size() == 0) begin
                        chk("rvalid_unexpected", 32'(rvalid), 32'd0);
                    end else begin
                        e = sb[0];
                        if (!front_seen) begin
                            chk("r_latency", 32'(cyc), 32'(e.hs));
                            front_seen = 1;
                        end
                        chk("rdata", rdata, e.data);
                        chk("rresp", 32'(rresp), 32'(e.resp));
                        chk("arready_in_resp", 32'(arready), 32'd0);
                        if (rready) begin
                            last_rdata = rdata;
                            last_rresp = rresp;
                            void'(sb.pop_front());
                            front_seen = 0;
                            r_done++;
                        end
                    end
                end else if (sb.size() > 0) begin
                    if (front_seen || cyc > sb[0].hs) begin
                        chk("rvalid_present", 32'(rvalid), 32'd1);
                        void'(sb.pop_front());
                        front_seen = 0;
                        r_done++;
                    end
                end
            end
        end
    end

    task automatic release_reset();
        @(negedge clk);
        rst_n = 1;
        tick();
        chk("arready_edge1", 32'(arready), 32'd0);
        tick();
        chk("arready_edge2", 32'(arready), 32'd1);
    endtask

    initial begin
        logic [9:0] a;
        rst_n = 0; arvalid = 0; araddr = '0; rready = 0;
        mm2s_halted = 0; mm2s_idle = 0; s2mm_halted = 0; s2mm_idle = 0;
        mm2s_ioc = 0; s2mm_ioc = 0; s2mm_err = 0;
        repeat (3) @(negedge clk);
        chk("reset_arready", 32'(arready), 32'd0);
        chk("reset_rvalid", 32'(rvalid), 32'd0);
        chk("reset_rdata", rdata, 32'd0);
        chk("reset_rresp", 32'(rresp), 32'd0);
        release_reset();

        // levels only
        s2mm_halted = 1; s2mm_idle = 1;
        do_read(10'h034, 0, 0);
        chk("s2mm_levels", last_rdata, 32'h0000_0003);
        chk("s2mm_levels_resp", 32'(last_rresp), 32'd0);

        // clear-on-read
        s2mm_ioc = 1; tick();
        do_read(10'h034, 0, 0);
        chk("ioc_first_read", 32'(last_rdata[12]), 32'd1);
        do_read(10'h034, 0, 0);
        chk("ioc_second_read", 32'(last_rdata[12]), 32'd0);

        // event coincident with the clearing handshake
        do_read(10'h034, 0, 1);
        chk("ioc_on_hs_read", 32'(last_rdata[12]), 32'd0);
        do_read(10'h034, 0, 0);
        chk("ioc_after_hs_read", 32'(last_rdata[12]), 32'd1);

        // decode corners
        do_read(10'h035, 0, 0);
        chk("misaligned_resp", 32'(last_rresp), 32'd2);
        chk("misaligned_data", last_rdata, 32'd0);
        do_read(10'h010, 0, 0);
        chk("unmapped_resp", 32'(last_rresp), 32'd0);
        chk("unmapped_data", last_rdata, 32'd0);

        // back-pressure while a level toggles
        mm2s_halted = 1; mm2s_idle = 1;
        do_read(10'h004, 5, 0);

        // reset in the middle of a response
        mm2s_ioc = 1; s2mm_err = 1; tick();
        araddr = 10'h004; arvalid = 1; rready = 0;
        for (int n = 0; n < 20 && !last_hs; n++) tick();
        arvalid = 0;
        tick();
        #3 rst_n = 0;
        #1;
        chk("midreset_rvalid", 32'(rvalid), 32'd0);
        chk("midreset_arready", 32'(arready), 32'd0);
        chk("midreset_rdata", rdata, 32'd0);
        sb.delete(); front_seen = 0;
        m_mm2s_ioc = 0; m_s2mm_ioc = 0; m_s2mm_err = 0;
        @(negedge clk);
        s2mm_ioc = 1; mm2s_ioc = 1; tick();
        release_reset();
        do_read(10'h004, 0, 0);
        chk("post_reset_mm2s_ioc", 32'(last_rdata[12]), 32'd0);
        do_read(10'h034, 0, 0);
        chk("post_reset_s2mm_sticky", 32'(last_rdata & 32'h0000_1010), 32'd0);

        // randomized traffic
        rand_ev = 1;
        for (int i = 0; i < 150; i++) begin
            case ($urandom_range(0, 4))
                0: a = 10'h004;
                1: a = 10'h034;
                2: a = 10'($urandom) & 10'h3FC;
                3: a = 10'($urandom);
                default: a = ($urandom_range(0, 1) == 0) ? 10'h004 : 10'h034;
            endcase
            do_read(a, $urandom_range(0, 3), ($urandom_range(0, 4) == 0));
            if ($urandom_range(0, 2) == 0) tick();
        end
        rand_ev = 0;
        repeat (3) tick();
        chk("scoreboard_empty", 32'(sb.size()), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout actual=running required=finished");
        $fatal(1, "timeout");
    end

endmodule

// File: doc/lite_read_slave.md
LITE_READ_SLAVE -- requirements
Module: lite_read_slave

Interface
REQ-001 SHALL have parameter ADDR_WIDTH, default 10, AXI-Lite address width.
REQ-002 SHALL have parameter DATA_WIDTH, default 32, AXI-Lite data width (only 32 supported).
REQ-003 SHALL have parameter MM2S_SR_ADDR, default 10'h004, MM2S status register offset.
REQ-004 SHALL have parameter S2MM_SR_ADDR, default 10'h034, S2MM status register offset (DMASR).
REQ-005 SHALL have port clk  input  1  single clock, all logic rising-edge.
REQ-006 SHALL have port rst_n  input  1  reset, asynchronous assert, active-low.
REQ-007 SHALL have port s_axi_lite_araddr  input  ADDR_WIDTH  read address.
REQ-008 SHALL have port s_axi_lite_arvalid  input  1  address valid.
REQ-009 SHALL have port s_axi_lite_arready  output  1  address ready, registered.
REQ-010 SHALL have port s_axi_lite_rdata  output  DATA_WIDTH  read data, registered.
REQ-011 SHALL have port s_axi_lite_rresp  output  2  response, 2'b00 OKAY, 2'b10 SLVERR.
REQ-012 SHALL have port s_axi_lite_rvalid  output  1  read data valid, registered.
REQ-013 SHALL have port s_axi_lite_rready  input  1  master ready for data.
REQ-014 SHALL have ports mm2s_halted, mm2s_idle, s2mm_halted, s2mm_idle  input  1 each  live channel levels.
REQ-015 SHALL have ports mm2s_ioc, s2mm_ioc, s2mm_err  input  1 each  one-cycle event pulses.

Function
REQ-016 SHALL implement FSM states INIT, IDLE, RESP; INIT->IDLE unconditionally; IDLE->RESP on arvalid&arready; RESP->IDLE on rvalid&rready.
REQ-017 SHALL drive arready=1 only in IDLE and rvalid=1 only in RESP; one read outstanding at most.
REQ-018 SHALL capture rdata/rresp at the address handshake edge and assert rvalid the following cycle (latency 1 cycle).
REQ-019 SHALL hold rdata, rresp, rvalid stable in RESP until rready; rready while not in RESP is ignored.
REQ-020 SHALL permit back-to-back reads every 2 cycles minimum (arready rises the cycle after the R handshake).
REQ-021 SHALL return MM2S_DMASR at MM2S_SR_ADDR: bit0 mm2s_halted, bit1 mm2s_idle, bit12 mm2s IOC sticky, other bits 0.
REQ-022 SHALL return S2MM_DMASR at S2MM_SR_ADDR: bit0 s2mm_halted, bit1 s2mm_idle, bit4 s2mm error sticky, bit12 s2mm IOC sticky, other bits 0.
REQ-023 SHALL return rdata=0, rresp=OKAY for any other word-aligned address.
REQ-024 SHALL return rdata=0, rresp=SLVERR when araddr[1:0]!=0.
REQ-025 SHALL set a sticky bit on its event pulse and clear it on the address handshake of its own register (clear-on-read).
REQ-026 SHALL give set priority over clear: pulse coincident with the clearing handshake leaves the bit 1; captured rdata shows pre-edge value.
REQ-027 SHALL sample level inputs (halted/idle) at the handshake edge; later changes do not alter held rdata.
REQ-028 SHALL continue accumulating sticky bits while in RESP.

Reset
REQ-029 SHALL on rst_n=0 asynchronously force state INIT, arready=0, rvalid=0, rdata=0, rresp=2'b00, all sticky bits 0.
REQ-030 SHALL abandon any in-flight response on reset mid-operation; first arready=1 is the second rising edge after rst_n deasserts.
REQ-031 SHALL ignore event pulses while rst_n=0.

Structure
REQ-032 SHALL place register offsets, DMASR bit positions, RESP codes and state encodings in shared package dma_lite_pkg, also used by the read master.
REQ-033 SHALL instantiate one sub-module lite_sticky_bit (set, clear, set-priority, async reset) per sticky bit; nothing else sub-moduled.

Verification
REQ-034 SHALL cover: s2mm_halted=1,s2mm_idle=1, read 0x034, rready=1 -> rvalid 1 cycle after AR handshake, rdata=32'h0000_0003, rresp=00.
REQ-035 SHALL cover: s2mm_ioc pulse, read 0x034 twice -> first rdata bit12=1, second bit12=0.
REQ-036 SHALL cover: s2mm_ioc pulse on the AR handshake cycle of a 0x034 read -> rdata bit12=0, next read bit12=1.
REQ-037 SHALL cover: read 0x035 -> rresp=10, rdata=0; read 0x010 -> rresp=00, rdata=0.
REQ-038 SHALL cover: rready held 0 for 5 cycles while mm2s_idle toggles -> rvalid/rdata stable, arready=0 throughout.
REQ-039 SHALL cover: rst_n pulsed low in RESP -> rvalid=0 immediately, sticky bits 0, arready=1 two edges after release.
